mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single main-memory port between the instruction-fetch side and the data (load/store) side of the CPU. It sits between the pipeline, with the data cache in front of the D-side on hits, and the variable-latency memory. It serialises requests with a round-robin grant, latches each request's attributes, runs the req/ack handshake with memory, and returns read data with a one-cycle ready pulse. It also drives per-side stall signals to the hazard unit.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, level, held until i_ready
- i_addr  in  ADDR_WIDTH  fetch address
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  DATA_WIDTH  fetched word, held until next I completion
- i_stall  out  1  i_req && !i_ready
- d_req  in  1  data request, level, held until d_ready
- d_wen  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_width  in  3  access width code (000 W, 001 H, 010 B, 101 HU, 110 BU), passed through
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_WIDTH  load data, held until next D load completion
- d_stall  out  1  d_req && !d_ready
- mem_req  out  1  memory request, high for entire transaction
- mem_wen  out  1  latched d_wen; 0 for I-side
- mem_addr  out  ADDR_WIDTH  latched address
- mem_wdata  out  DATA_WIDTH  latched store data; 0 for I-side
- mem_width  out  3  latched d_width; 000 for I-side
- mem_ack  in  1  memory completion, single cycle; mem_rdata valid same cycle
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D.
- IDLE: no request -> stay. Only i_req -> GRANT_I. Only d_req -> GRANT_D. Both -> grant the side not granted last (last_grant register). On tie after reset, last_grant = I, so D wins first.
- On the IDLE->GRANT transition, register addr, wen, wdata, and width from the winning side. The I-side forces wen=0, wdata=0, width=000. Set last_grant.
- GRANT_x: mem_req=1 and mem_* drive the latched values. Hold until mem_ack. On mem_ack, capture mem_rdata into x_rdata, except for D-side stores, where d_rdata is unchanged. Then go to DONE_x.
- DONE_x: x_ready=1 for exactly this cycle, mem_req=0. Always go to IDLE next, giving one bubble cycle before re-arbitration.
- Requester changes to addr/wdata/wen after grant are ignored.
- Requester deassertion of req while in GRANT_x or DONE_x does not abort the transaction. The transaction completes and ready still pulses.
- mem_ack outside GRANT_x is ignored; no state or data change.
- Stall outputs are combinational from req and ready. There is no stall in the DONE cycle for the completing side.

## Timing
- Reset (async assert, sync-free deassert) forces:
  - state=IDLE, last_grant=I
  - mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_width=000
  - i_ready=d_ready=0, i_rdata=d_rdata=0
  - i_stall/d_stall follow their equations.
- Reset mid-transaction drops mem_req immediately. The in-flight access is lost and no ready pulse is issued.
- Latency, with req seen in IDLE at cycle 0:
  - mem_req from cycle 1.
  - mem_ack at cycle 1+L (L >= 0) -> x_ready at cycle 2+L.
  - Minimum request-to-ready is 2 cycles.
- Back-to-back: a req held high through DONE is re-arbitrated in the following IDLE cycle. Minimum spacing of grants is 3 cycles at L=0.
- Under continuous contention, grants alternate I, D, I, D. Neither side waits more than one foreign transaction.
- All outputs except stalls are registered.

## Test plan
- Reset: drive rst_n=0 mid-GRANT_D with mem_req=1 -> mem_req=0 same cycle, all outputs 0. After release with both reqs high, first grant goes to D.
- Single fetch: i_req=1, i_addr=0x0000_0010, mem_ack at L=2 with mem_rdata=0xDEAD_BEEF -> mem_addr=0x10 and mem_wen=0 from cycle 1. i_ready pulses at cycle 4, i_rdata=0xDEAD_BEEF held afterwards.
- Store: d_req=1, d_wen=1, d_addr=0x100, d_wdata=0x1234_5678, d_width=010, L=0 -> mem_wen=1, mem_wdata=0x1234_5678, mem_width=010 in cycle 1. d_ready at cycle 2, d_rdata unchanged.
- Contention: i_req and d_req held high for 4 transactions, L=1 -> grant order D, I, D, I. Each ready pulse is one cycle, and the stall of the waiting side stays high throughout.
- Attribute latching: change d_addr from 0x200 to 0x300 one cycle after grant -> mem_addr stays 0x200 until DONE.
- Stray ack and drop: pulse mem_ack in IDLE -> no ready, no data change. Drop i_req during GRANT_I -> transaction completes and i_ready still pulses.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data sides, the arbiter and main memory.
// The arbiter connects through the slave view; the CPU/memory environment drives the master view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_stall;

  logic                  d_req;
  logic                  d_wen;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [2:0]            d_width;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_stall;

  logic                  mem_req;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [2:0]            mem_width;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_width, mem_ack, mem_rdata,
    input  i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_width
  );

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_width, mem_ack, mem_rdata,
    output i_ready, i_rdata, i_stall, d_ready, d_rdata, d_stall,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_width
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between the
// instruction-fetch and data sides, with registered handshakes and stall outputs.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t                r_state;
  logic                  r_last_d;
  logic                  r_mem_req;
  logic                  r_mem_wen;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [2:0]            r_mem_width;
  logic                  r_i_ready;
  logic                  r_d_ready;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  // I wins when it is alone, or on a tie when D was served last.
  logic w_pick_i;
  assign w_pick_i = bus.i_req && (!bus.d_req || r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_width <= 3'b000;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      // NOTE: every register here uses <= so all branches see the pre-edge
      // values; the ready defaults below are overridden only on mem_ack.
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pick_i) begin
            r_state     <= GRANT_I;
            r_last_d    <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= bus.i_addr;
            r_mem_wdata <= '0;
            r_mem_width <= 3'b000;
          end else if (bus.d_req) begin
            r_state     <= GRANT_D;
            r_last_d    <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_wen   <= bus.d_wen;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_mem_width <= bus.d_width;
          end
        end
        GRANT_I: begin
          if (bus.mem_ack) begin
            r_state   <= DONE_I;
            r_mem_req <= 1'b0;
            r_i_ready <= 1'b1;
            r_i_rdata <= bus.mem_rdata;
          end
        end
        GRANT_D: begin
          if (bus.mem_ack) begin
            r_state   <= DONE_D;
            r_mem_req <= 1'b0;
            r_d_ready <= 1'b1;
            if (!r_mem_wen) r_d_rdata <= bus.mem_rdata;
          end
        end
        DONE_I, DONE_D: r_state <= IDLE;
        default:        r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_wen   = r_mem_wen;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_width = r_mem_width;
  assign bus.i_ready   = r_i_ready;
  assign bus.d_ready   = r_d_ready;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.i_stall   = bus.i_req && !r_i_ready;
  assign bus.d_stall   = bus.d_req && !r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: last side served and the data each side should be holding.
  bit          m_last_d;
  logic [31:0] m_i_rdata;
  logic [31:0] m_d_rdata;
  logic [2:0]  wcodes [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_stalls(input bit ei_rdy, input bit ed_rdy);
    check("i_stall", 32'(bus.i_stall), 32'(bus.i_req && !ei_rdy));
    check("d_stall", 32'(bus.d_stall), 32'(bus.d_req && !ed_rdy));
  endtask

  task automatic idle_check(input string tag);
    check({tag, ".mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, ".i_ready"}, 32'(bus.i_ready), 32'd0);
    check({tag, ".d_ready"}, 32'(bus.d_ready), 32'd0);
    check({tag, ".i_rdata"}, bus.i_rdata, m_i_rdata);
    check({tag, ".d_rdata"}, bus.d_rdata, m_d_rdata);
    check_stalls(1'b0, 1'b0);
  endtask

  // Called in an IDLE cycle with the winner's request up; returns in the DONE cycle.
  task automatic run_grant(input bit gd, input int lat, input logic [31:0] rd,
                           input logic [31:0] ea, input logic ew, input logic [31:0] ewd,
                           input logic [2:0] ewi, input bit scramble, input bit drop);
    step();
    for (int k = 0; k <= lat; k++) begin
      check("grant.mem_req",   32'(bus.mem_req),   32'd1);
      check("grant.mem_addr",  bus.mem_addr,       ea);
      check("grant.mem_wen",   32'(bus.mem_wen),   32'(ew));
      check("grant.mem_wdata", bus.mem_wdata,      ewd);
      check("grant.mem_width", 32'(bus.mem_width), 32'(ewi));
      check("grant.i_ready",   32'(bus.i_ready),   32'd0);
      check("grant.d_ready",   32'(bus.d_ready),   32'd0);
      check_stalls(1'b0, 1'b0);
      if (k == 0 && scramble) begin
        if (gd) begin
          bus.d_addr  = bus.d_addr + 32'h100;
          bus.d_wdata = ~bus.d_wdata;
          bus.d_wen   = ~bus.d_wen;
          bus.d_width = 3'b110;
        end else begin
          bus.i_addr = bus.i_addr ^ 32'h0000_FFF0;
        end
      end
      if (k == 0 && drop) begin
        if (gd) bus.d_req = 1'b0;
        else    bus.i_req = 1'b0;
      end
      if (k == lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
      end
      step();
    end
    bus.mem_ack = 1'b0;
    if (!gd)     m_i_rdata = rd;
    else if (!ew) m_d_rdata = rd;
    check("done.mem_req", 32'(bus.mem_req), 32'd0);
    check("done.i_ready", 32'(bus.i_ready), 32'(!gd));
    check("done.d_ready", 32'(bus.d_ready), 32'(gd));
    check("done.i_rdata", bus.i_rdata, m_i_rdata);
    check("done.d_rdata", bus.d_rdata, m_d_rdata);
    check_stalls(!gd, gd);
  endtask

  // Applies the round-robin rule to the requests currently driven and runs the transaction.
  task automatic arbitrate(input int lat, input logic [31:0] rd, input bit scramble,
                           input bit drop, output bit gd);
    logic [31:0] ea;
    logic [31:0] ewd;
    logic        ew;
    logic [2:0]  ewi;
    gd  = bus.d_req && (!bus.i_req || !m_last_d);
    ea  = gd ? bus.d_addr  : bus.i_addr;
    ew  = gd ? bus.d_wen   : 1'b0;
    ewd = gd ? bus.d_wdata : 32'h0;
    ewi = gd ? bus.d_width : 3'b000;
    m_last_d = gd;
    run_grant(gd, lat, rd, ea, ew, ewd, ewi, scramble, drop);
  endtask

  initial begin
    bit gd;
    wcodes = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
    m_last_d  = 1'b0;
    m_i_rdata = '0;
    m_d_rdata = '0;
    rst_n         = 1'b0;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_wen     = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_width   = 3'b000;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    idle_check("reset");
    check("reset.mem_wen",   32'(bus.mem_wen),   32'd0);
    check("reset.mem_addr",  bus.mem_addr,       32'd0);
    check("reset.mem_wdata", bus.mem_wdata,      32'd0);
    check("reset.mem_width", 32'(bus.mem_width), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of a D grant
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h40;
    step();
    check("rst_mid.pre_mem_req", 32'(bus.mem_req), 32'd1);
    check("rst_mid.pre_addr",    bus.mem_addr,     32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.mem_req",  32'(bus.mem_req), 32'd0);
    check("rst_mid.mem_addr", bus.mem_addr,     32'd0);
    check("rst_mid.d_ready",  32'(bus.d_ready), 32'd0);
    check("rst_mid.d_stall",  32'(bus.d_stall), 32'd1);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h80;
    m_last_d   = 1'b0;
    step();
    rst_n = 1'b1;

    // Continuous contention at L=1: both requests stay high through DONE
    for (int j = 0; j < 4; j++) begin
      arbitrate(1, $urandom, 1'b0, 1'b0, gd);
      check("contend.order", 32'(gd), 32'(j % 2 == 0));
      step();
      idle_check("contend.idle");
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();
    idle_check("contend.end");

    // Single fetch, L=2
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0010;
    arbitrate(2, 32'hDEAD_BEEF, 1'b0, 1'b0, gd);
    bus.i_req = 1'b0;
    step();
    idle_check("fetch.after");

    // Store, L=0: d_rdata must keep its last load value
    bus.d_req   = 1'b1;
    bus.d_wen   = 1'b1;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'h1234_5678;
    bus.d_width = 3'b010;
    arbitrate(0, 32'hA5A5_A5A5, 1'b0, 1'b0, gd);
    bus.d_req = 1'b0;
    step();
    idle_check("store.after");

    // Attribute latching: d_addr moves 0x200 -> 0x300 after the grant
    bus.d_req   = 1'b1;
    bus.d_wen   = 1'b0;
    bus.d_addr  = 32'h200;
    bus.d_width = 3'b000;
    arbitrate(2, 32'hCAFE_0001, 1'b1, 1'b0, gd);
    bus.d_req = 1'b0;
    step();
    idle_check("latch.after");

    // Stray acks in IDLE, then i_req dropped during GRANT_I
    for (int j = 0; j < 2; j++) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0_0000 + 32'(j);
      step();
      bus.mem_ack = 1'b0;
      idle_check("stray");
    end
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0400;
    arbitrate(1, 32'h0BAD_F00D, 1'b0, 1'b1, gd);
    step();
    idle_check("drop.after");

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      if (!bus.i_req && $urandom_range(0, 1) == 1) begin
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
      end
      if (!bus.d_req && $urandom_range(0, 1) == 1) begin
        bus.d_req   = 1'b1;
        bus.d_wen   = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_width = wcodes[$urandom_range(0, 4)];
      end
      if (!bus.i_req && !bus.d_req) begin
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        step();
        bus.mem_ack = 1'b0;
        idle_check("rand.idle");
      end else begin
        arbitrate($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), gd);
        if (gd) bus.d_req = 1'b0;
        else    bus.i_req = 1'b0;
        step();
        idle_check("rand.after");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
